// File: rtl/controle_irrigacao_pkg.sv
// Shared types for the irrigation round sequencer: states, operand selection, payloads.
package controle_irrigacao_pkg;

    localparam int unsigned LARG_DADO = 4;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CMP_CFG   = 3'd1,
        CMP_NIVEL = 3'd2,
        CMP_MIN   = 3'd3,
        CMP_MAX   = 3'd4,
        ATUALIZA  = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        SEL_CFG   = 2'd0,
        SEL_NIVEL = 2'd1,
        SEL_MIN   = 2'd2,
        SEL_MAX   = 2'd3
    } sel_op_t;

    // Snapshot of the data inputs taken at the start of a round
    typedef struct packed {
        logic [LARG_DADO-1:0] umidade;
        logic [LARG_DADO-1:0] lim_min;
        logic [LARG_DADO-1:0] lim_max;
        logic [LARG_DADO-1:0] nivel;
        logic [LARG_DADO-1:0] nivel_min;
    } amostra_t;

    // One comparator operand pair
    typedef struct packed {
        logic [LARG_DADO-1:0] a;
        logic [LARG_DADO-1:0] b;
    } operandos_t;

    // Operand pair driven to the shared comparator for each check
    function automatic operandos_t seleciona(input sel_op_t sel, input amostra_t s);
        operandos_t r;
        r = '0;
        case (sel)
            SEL_CFG:   begin r.a = s.lim_min; r.b = s.lim_max;   end
            SEL_NIVEL: begin r.a = s.nivel;   r.b = s.nivel_min; end
            SEL_MIN:   begin r.a = s.umidade; r.b = s.lim_min;   end
            SEL_MAX:   begin r.a = s.umidade; r.b = s.lim_max;   end
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comparador_4b.sv
// Combinational magnitude comparator shared by the irrigation round.
module comparador_4b
    import controle_irrigacao_pkg::*;
(
    input  logic [LARG_DADO-1:0] a,
    input  logic [LARG_DADO-1:0] b,
    output logic                 igual_c,
    output logic                 maior_c,
    output logic                 menor_c
);

    // Plain unsigned compare
    always_comb begin
        igual_c = (a == b);
        maior_c = (a > b);
        menor_c = (a < b);
    end

endmodule

// File: rtl/irrigacao_topo.sv
// Thin wrapper: sequencer plus the shared magnitude comparator.
module irrigacao_topo
    import controle_irrigacao_pkg::*;
#(
    parameter int unsigned MAX_RODADAS = 8,
    parameter int unsigned LARG_CONT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iniciar,
    input  logic [LARG_DADO-1:0] umidade,
    input  logic [LARG_DADO-1:0] lim_min,
    input  logic [LARG_DADO-1:0] lim_max,
    input  logic [LARG_DADO-1:0] nivel,
    input  logic [LARG_DADO-1:0] nivel_min,
    output logic                 valvula,
    output logic                 alarme,
    output logic                 erro_cfg,
    output logic                 estouro,
    output logic                 ocupado,
    output logic                 pronto
);

    logic [LARG_DADO-1:0] comp_a;
    logic [LARG_DADO-1:0] comp_b;
    logic                 igual;
    logic                 maior;
    logic                 menor;

    controle_irrigacao #(
        .MAX_RODADAS(MAX_RODADAS),
        .LARG_CONT  (LARG_CONT)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .iniciar  (iniciar),
        .umidade  (umidade),
        .lim_min  (lim_min),
        .lim_max  (lim_max),
        .nivel    (nivel),
        .nivel_min(nivel_min),
        .comp_a   (comp_a),
        .comp_b   (comp_b),
        .aIGUALb  (igual),
        .aMAIORb  (maior),
        .aMENORb  (menor),
        .valvula  (valvula),
        .alarme   (alarme),
        .erro_cfg (erro_cfg),
        .estouro  (estouro),
        .ocupado  (ocupado),
        .pronto   (pronto)
    );

    comparador_4b u_cmp (
        .a      (comp_a),
        .b      (comp_b),
        .igual_c(igual),
        .maior_c(maior),
        .menor_c(menor)
    );

endmodule

// File: rtl/controle_irrigacao.sv
// Irrigation round sequencer: time-shares one comparator over four checks,
// then updates valve/alarm outputs with hysteresis and an on-time watchdog.
module controle_irrigacao
    import controle_irrigacao_pkg::*;
#(
    parameter int unsigned MAX_RODADAS = 8,
    parameter int unsigned LARG_CONT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iniciar,
    input  logic [LARG_DADO-1:0] umidade,
    input  logic [LARG_DADO-1:0] lim_min,
    input  logic [LARG_DADO-1:0] lim_max,
    input  logic [LARG_DADO-1:0] nivel,
    input  logic [LARG_DADO-1:0] nivel_min,
    output logic [LARG_DADO-1:0] comp_a,
    output logic [LARG_DADO-1:0] comp_b,
    input  logic                 aIGUALb,
    input  logic                 aMAIORb,
    input  logic                 aMENORb,
    output logic                 valvula,
    output logic                 alarme,
    output logic                 erro_cfg,
    output logic                 estouro,
    output logic                 ocupado,
    output logic                 pronto
);

    localparam logic [LARG_CONT-1:0] CONT_LIMITE = LARG_CONT'(MAX_RODADAS);
    localparam logic [LARG_CONT-1:0] CONT_SAT    = {LARG_CONT{1'b1}};

    estado_t              estado_q, estado_d;
    amostra_t             amostra_q, amostra_d;
    amostra_t             amostra_in;
    logic [LARG_DADO-1:0] comp_a_q, comp_a_d;
    logic [LARG_DADO-1:0] comp_b_q, comp_b_d;
    logic                 cfg_ruim_q, cfg_ruim_d;
    logic                 baixo_q, baixo_d;
    logic                 seco_q, seco_d;
    logic                 molhado_q, molhado_d;
    logic                 valvula_q, valvula_d;
    logic                 alarme_q, alarme_d;
    logic                 erro_cfg_q, erro_cfg_d;
    logic                 estouro_q, estouro_d;
    logic                 ocupado_q, ocupado_d;
    logic                 pronto_q, pronto_d;
    logic [LARG_CONT-1:0] cont_q, cont_d;

    logic                 maior_c;
    logic                 menor_c;
    logic [LARG_CONT-1:0] cont_inc;
    logic                 valv_tmp;
    logic                 est_tmp;
    operandos_t           par;

    assign amostra_in = '{umidade: umidade, lim_min: lim_min, lim_max: lim_max,
                          nivel: nivel, nivel_min: nivel_min};

    // Strict flags: equal operands never count as greater or smaller
    assign maior_c = aMAIORb & ~aIGUALb;
    assign menor_c = aMENORb & ~aIGUALb;

    // Next-state, operand sequencing and round update
    always_comb begin
        estado_d   = estado_q;
        amostra_d  = amostra_q;
        comp_a_d   = comp_a_q;
        comp_b_d   = comp_b_q;
        cfg_ruim_d = cfg_ruim_q;
        baixo_d    = baixo_q;
        seco_d     = seco_q;
        molhado_d  = molhado_q;
        valvula_d  = valvula_q;
        alarme_d   = alarme_q;
        erro_cfg_d = erro_cfg_q;
        estouro_d  = estouro_q;
        ocupado_d  = ocupado_q;
        pronto_d   = 1'b0;
        cont_d     = cont_q;
        par        = '0;
        valv_tmp   = valvula_q;
        est_tmp    = estouro_q;
        cont_inc   = (cont_q == CONT_SAT) ? cont_q : cont_q + LARG_CONT'(1);

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    amostra_d = amostra_in;
                    par       = seleciona(SEL_CFG, amostra_in);
                    comp_a_d  = par.a;
                    comp_b_d  = par.b;
                    ocupado_d = 1'b1;
                    estado_d  = CMP_CFG;
                end
            end
            CMP_CFG: begin
                cfg_ruim_d = maior_c;
                par        = seleciona(SEL_NIVEL, amostra_q);
                comp_a_d   = par.a;
                comp_b_d   = par.b;
                estado_d   = CMP_NIVEL;
            end
            CMP_NIVEL: begin
                baixo_d  = menor_c;
                par      = seleciona(SEL_MIN, amostra_q);
                comp_a_d = par.a;
                comp_b_d = par.b;
                estado_d = CMP_MIN;
            end
            CMP_MIN: begin
                seco_d   = menor_c;
                par      = seleciona(SEL_MAX, amostra_q);
                comp_a_d = par.a;
                comp_b_d = par.b;
                estado_d = CMP_MAX;
            end
            CMP_MAX: begin
                molhado_d = maior_c;
                estado_d  = ATUALIZA;
            end
            ATUALIZA: begin
                // Lockout survives only while the soil stays dry
                est_tmp = estouro_q & seco_q;
                if (cfg_ruim_q | baixo_q) begin
                    valv_tmp = 1'b0;
                end else if (est_tmp) begin
                    valv_tmp = 1'b0;
                end else if (seco_q) begin
                    valv_tmp = 1'b1;
                end else if (molhado_q) begin
                    valv_tmp = 1'b0;
                end else begin
                    valv_tmp = valvula_q;
                end
                if (valv_tmp && (cont_inc >= CONT_LIMITE)) begin
                    valv_tmp = 1'b0;
                    est_tmp  = 1'b1;
                end
                cont_d     = valv_tmp ? cont_inc : '0;
                valvula_d  = valv_tmp;
                estouro_d  = est_tmp;
                alarme_d   = baixo_q;
                erro_cfg_d = cfg_ruim_q;
                ocupado_d  = 1'b0;
                pronto_d   = 1'b1;
                estado_d   = OCIOSO;
            end
            default: begin
                estado_d  = OCIOSO;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            amostra_q  <= '0;
            comp_a_q   <= '0;
            comp_b_q   <= '0;
            cfg_ruim_q <= 1'b0;
            baixo_q    <= 1'b0;
            seco_q     <= 1'b0;
            molhado_q  <= 1'b0;
            valvula_q  <= 1'b0;
            alarme_q   <= 1'b0;
            erro_cfg_q <= 1'b0;
            estouro_q  <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            cont_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            amostra_q  <= amostra_d;
            comp_a_q   <= comp_a_d;
            comp_b_q   <= comp_b_d;
            cfg_ruim_q <= cfg_ruim_d;
            baixo_q    <= baixo_d;
            seco_q     <= seco_d;
            molhado_q  <= molhado_d;
            valvula_q  <= valvula_d;
            alarme_q   <= alarme_d;
            erro_cfg_q <= erro_cfg_d;
            estouro_q  <= estouro_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
            cont_q     <= cont_d;
        end
    end

    assign comp_a   = comp_a_q;
    assign comp_b   = comp_b_q;
    assign valvula  = valvula_q;
    assign alarme   = alarme_q;
    assign erro_cfg = erro_cfg_q;
    assign estouro  = estouro_q;
    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Self-checking bench for controle_irrigacao (and the irrigacao_topo wrapper).
module tb_controle_irrigacao;

    localparam int MAX = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       iniciar;
    logic [3:0] umidade, lim_min, lim_max, nivel, nivel_min;
    logic [3:0] comp_a, comp_b;
    logic       a_eq, a_gt, a_lt;
    logic       valvula, alarme, erro_cfg, estouro, ocupado, pronto;
    logic       t_valvula, t_alarme, t_erro_cfg, t_estouro, t_ocupado, t_pronto;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit m_valv;
    bit m_est;
    int m_rod;

    always #5 clk = ~clk;

    // Behavioural comparator for the bare controller
    assign a_eq = (comp_a == comp_b);
    assign a_gt = (comp_a > comp_b);
    assign a_lt = (comp_a < comp_b);

    controle_irrigacao #(.MAX_RODADAS(MAX), .LARG_CONT(4)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar),
        .umidade(umidade), .lim_min(lim_min), .lim_max(lim_max),
        .nivel(nivel), .nivel_min(nivel_min),
        .comp_a(comp_a), .comp_b(comp_b),
        .aIGUALb(a_eq), .aMAIORb(a_gt), .aMENORb(a_lt),
        .valvula(valvula), .alarme(alarme), .erro_cfg(erro_cfg),
        .estouro(estouro), .ocupado(ocupado), .pronto(pronto)
    );

    irrigacao_topo #(.MAX_RODADAS(MAX), .LARG_CONT(4)) topo (
        .clk(clk), .rst(rst), .iniciar(iniciar),
        .umidade(umidade), .lim_min(lim_min), .lim_max(lim_max),
        .nivel(nivel), .nivel_min(nivel_min),
        .valvula(t_valvula), .alarme(t_alarme), .erro_cfg(t_erro_cfg),
        .estouro(t_estouro), .ocupado(t_ocupado), .pronto(t_pronto)
    );

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Spec-level model of one completed round
    task automatic modelo(input logic [3:0] u, mn, mx, n, nm,
                          output logic ev, eal, eerr, eest);
        bit cfg, baixo, seco, molhado, v;
        cfg     = (mn > mx);
        baixo   = (n < nm);
        seco    = (u < mn);
        molhado = (u > mx);
        if (!seco) m_est = 1'b0;
        if (cfg || baixo)  v = 1'b0;
        else if (m_est)    v = 1'b0;
        else if (seco)     v = 1'b1;
        else if (molhado)  v = 1'b0;
        else               v = m_valv;
        if (v) begin
            m_rod++;
            if (m_rod >= MAX) begin
                v     = 1'b0;
                m_est = 1'b1;
            end
        end
        if (!v) m_rod = 0;
        m_valv = v;
        ev = v; eal = baixo; eerr = cfg; eest = m_est;
    endtask

    task automatic aplica_reset();
        @(negedge clk);
        rst = 1'b1; iniciar = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valv = 1'b0; m_est = 1'b0; m_rod = 0;
    endtask

    // One full round with operand-sequence and result checks
    task automatic rodada(input string tag, input logic [3:0] u, mn, mx, n, nm,
                          input bit segura, input logic ev, eal, eerr, eest);
        @(negedge clk);
        umidade = u; lim_min = mn; lim_max = mx; nivel = n; nivel_min = nm;
        iniciar = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".e0.comp_a"}, comp_a, mn);
        chk({tag, ".e0.comp_b"}, comp_b, mx);
        chk({tag, ".e0.ocupado"}, ocupado, 1);
        chk({tag, ".e0.pronto"}, pronto, 0);
        umidade = 4'($urandom); lim_min = 4'($urandom); lim_max = 4'($urandom);
        nivel = 4'($urandom); nivel_min = 4'($urandom);
        if (!segura) iniciar = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".e1.comp_a"}, comp_a, n);
        chk({tag, ".e1.comp_b"}, comp_b, nm);
        @(posedge clk); #1;
        chk({tag, ".e2.comp_a"}, comp_a, u);
        chk({tag, ".e2.comp_b"}, comp_b, mn);
        @(posedge clk); #1;
        chk({tag, ".e3.comp_a"}, comp_a, u);
        chk({tag, ".e3.comp_b"}, comp_b, mx);
        @(posedge clk); #1;
        chk({tag, ".e4.comp_a"}, comp_a, u);
        chk({tag, ".e4.comp_b"}, comp_b, mx);
        chk({tag, ".e4.pronto"}, pronto, 0);
        chk({tag, ".e4.ocupado"}, ocupado, 1);
        iniciar = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".pronto"}, pronto, 1);
        chk({tag, ".ocupado"}, ocupado, 0);
        chk({tag, ".valvula"}, valvula, ev);
        chk({tag, ".alarme"}, alarme, eal);
        chk({tag, ".erro_cfg"}, erro_cfg, eerr);
        chk({tag, ".estouro"}, estouro, eest);
        chk({tag, ".topo.pronto"}, t_pronto, 1);
        chk({tag, ".topo.valvula"}, t_valvula, ev);
        chk({tag, ".topo.alarme"}, t_alarme, eal);
        chk({tag, ".topo.erro_cfg"}, t_erro_cfg, eerr);
        chk({tag, ".topo.estouro"}, t_estouro, eest);
        @(posedge clk); #1;
        chk({tag, ".e6.pronto"}, pronto, 0);
        chk({tag, ".e6.topo.pronto"}, t_pronto, 0);
    endtask

    typedef struct {
        logic [3:0] u, mn, mx, n, nm;
        logic       v, al, err, est;
    } vec_t;

    localparam int NVEC = 14;
    vec_t tab[NVEC];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ev, eal, eerr, eest;
        logic [3:0] u, mn, mx, n, nm;

        // u, lim_min, lim_max, nivel, nivel_min -> valvula, alarme, erro_cfg, estouro
        tab[0]  = '{4'd3,  4'd5,  4'd10, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{4'd7,  4'd5,  4'd10, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[2]  = '{4'd11, 4'd5,  4'd10, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[3]  = '{4'd10, 4'd5,  4'd10, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[4]  = '{4'd5,  4'd5,  4'd10, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[5]  = '{4'd1,  4'd5,  4'd10, 4'd2, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[6]  = '{4'd1,  4'd12, 4'd6,  4'd8, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[7]  = '{4'd1,  4'd5,  4'd10, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[8]  = '{4'd1,  4'd5,  4'd10, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{4'd1,  4'd5,  4'd10, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[10] = '{4'd1,  4'd5,  4'd10, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[11] = '{4'd7,  4'd5,  4'd10, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[12] = '{4'd1,  4'd5,  4'd10, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[13] = '{4'd1,  4'd5,  4'd10, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; iniciar = 1'b0;
        umidade = '0; lim_min = '0; lim_max = '0; nivel = '0; nivel_min = '0;
        aplica_reset();
        #1;
        chk("reset.comp_a", comp_a, 0);
        chk("reset.comp_b", comp_b, 0);
        chk("reset.valvula", valvula, 0);
        chk("reset.alarme", alarme, 0);
        chk("reset.erro_cfg", erro_cfg, 0);
        chk("reset.estouro", estouro, 0);
        chk("reset.ocupado", ocupado, 0);
        chk("reset.pronto", pronto, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle.pronto", pronto, 0);

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            rodada($sformatf("tab%0d", i), tab[i].u, tab[i].mn, tab[i].mx, tab[i].n, tab[i].nm,
                   (i % 2) == 1, tab[i].v, tab[i].al, tab[i].err, tab[i].est);
        end

        // Random rounds against the reference model
        aplica_reset();
        for (int i = 0; i < 150; i++) begin
            u  = 4'($urandom_range(0, 15));
            mn = 4'($urandom_range(0, 10));
            mx = 4'(mn + 4'($urandom_range(0, 5)));
            if ($urandom_range(0, 7) == 0) mx = 4'($urandom_range(0, 15));
            n  = 4'($urandom_range(0, 15));
            nm = 4'($urandom_range(0, 6));
            modelo(u, mn, mx, n, nm, ev, eal, eerr, eest);
            rodada($sformatf("rnd%0d", i), u, mn, mx, n, nm, $urandom_range(0, 1) == 1,
                   ev, eal, eerr, eest);
        end

        // Reset in CMP_MIN aborts the round
        aplica_reset();
        modelo(4'd3, 4'd5, 4'd10, 4'd8, 4'd4, ev, eal, eerr, eest);
        rodada("pre_abort", 4'd3, 4'd5, 4'd10, 4'd8, 4'd4, 1'b0, ev, eal, eerr, eest);
        @(negedge clk);
        umidade = 4'd3; lim_min = 4'd5; lim_max = 4'd10; nivel = 4'd8; nivel_min = 4'd4;
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.comp_a", comp_a, 0);
        chk("abort.comp_b", comp_b, 0);
        chk("abort.valvula", valvula, 0);
        chk("abort.alarme", alarme, 0);
        chk("abort.erro_cfg", erro_cfg, 0);
        chk("abort.estouro", estouro, 0);
        chk("abort.ocupado", ocupado, 0);
        chk("abort.pronto", pronto, 0);
        @(negedge clk);
        rst = 1'b0;
        m_valv = 1'b0; m_est = 1'b0; m_rod = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort.nopronto%0d", k), pronto, 0);
        end
        modelo(4'd7, 4'd5, 4'd10, 4'd8, 4'd4, ev, eal, eerr, eest);
        rodada("post_abort", 4'd7, 4'd5, 4'd10, 4'd8, 4'd4, 1'b0, ev, eal, eerr, eest);

        // iniciar held high: one round every six cycles
        aplica_reset();
        umidade = 4'd3; lim_min = 4'd5; lim_max = 4'd10; nivel = 4'd8; nivel_min = 4'd4;
        iniciar = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b.pronto%0d", k), pronto, (k % 6) == 5);
            chk($sformatf("b2b.topo.pronto%0d", k), t_pronto, (k % 6) == 5);
            if ((k % 6) == 5) begin
                modelo(4'd3, 4'd5, 4'd10, 4'd8, 4'd4, ev, eal, eerr, eest);
                chk($sformatf("b2b.valvula%0d", k), valvula, ev);
                chk($sformatf("b2b.estouro%0d", k), estouro, eest);
            end
        end
        @(negedge clk);
        iniciar = 1'b0;
        repeat (8) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
